// File: rtl/dst_send_ctrl.sv
// Drains a finished result batch from the dst buffer and streams it out over valid/ready.
// A 2-entry skid FIFO (with bypass of the returning read word) decouples buffer reads from backpressure.
module dst_send_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              s_fin_in,
    output logic              dst_ready,
    output logic              buf_rden,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [15:0]       batch_cnt,
    output logic              err_overrun
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0] out_cnt;
    logic              rd_pend;
    logic [1:0]        fcnt;
    logic [DATA_W-1:0] f0, f1;
    logic [2:0]        occ;
    logic              xfer, last_xfer, start, push_st, pop_st;

    // The word returning from the buffer counts as FIFO content in the cycle it arrives.
    assign m_valid   = (fcnt != 2'd0) | rd_pend;
    assign m_data    = (fcnt != 2'd0) ? f0 : buf_rdata;
    assign xfer      = m_valid & m_ready;
    assign last_xfer = xfer & (out_cnt == ADDR_W'(DEPTH - 1));
    assign m_last    = m_valid & (out_cnt == ADDR_W'(DEPTH - 1));
    assign occ       = {1'b0, fcnt} + {2'b00, rd_pend};
    assign buf_raddr = rd_cnt[ADDR_W-1:0];
    assign dst_ready = (state == IDLE) & run & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state <= IDLE;
        else if (!run)   state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        buf_rden  = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (s_fin_in) begin
                    state_nxt = STREAM;
                    start     = 1'b1;
                end
            end
            STREAM: begin
                buf_rden = (rd_cnt < CNT_W'(DEPTH)) && (occ < 3'd2);
                if (last_xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt      <= '0;
            out_cnt     <= '0;
            rd_pend     <= 1'b0;
            err_overrun <= 1'b0;
            batch_cnt   <= '0;
        end else if (!run) begin
            rd_cnt      <= '0;
            out_cnt     <= '0;
            rd_pend     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            rd_pend <= buf_rden;
            if (start) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (buf_rden) rd_cnt  <= rd_cnt + CNT_W'(1);
                if (xfer)     out_cnt <= out_cnt + ADDR_W'(1);
            end
            if (s_fin_in && state == STREAM) err_overrun <= 1'b1;
            if (last_xfer) batch_cnt <= batch_cnt + 16'd1;
        end
    end

    // A returning word bypassed straight out is never stored.
    assign pop_st  = xfer & (fcnt != 2'd0);
    assign push_st = rd_pend & ~(xfer & (fcnt == 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= 2'd0;
            f0   <= '0;
            f1   <= '0;
        end else if (!run) begin
            fcnt <= 2'd0;
        end else begin
            case ({push_st, pop_st})
                2'b01: begin
                    f0   <= f1;
                    fcnt <= fcnt - 2'd1;
                end
                2'b10: begin
                    if (fcnt == 2'd0) f0 <= buf_rdata;
                    else              f1 <= buf_rdata;
                    fcnt <= fcnt + 2'd1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) begin
                        f0 <= buf_rdata;
                    end else begin
                        f0 <= f1;
                        f1 <= buf_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dst_send_ctrl.sv
// Bench for dst_send_ctrl: DEPTH=4 and DEPTH=1 instances, directed timing plus randomized backpressure.
module tb_dst_send_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_run = 1'b0, a_fin = 1'b0, a_rdy = 1'b0;
    logic          a_dst_ready, a_rden, a_mv, a_ml, a_err;
    logic [1:0]    a_raddr;
    logic [DW-1:0] a_rdata = '0, a_md;
    logic [15:0]   a_bc;

    logic          b_run = 1'b0, b_fin = 1'b0, b_rdy = 1'b0;
    logic          b_dst_ready, b_rden, b_mv, b_ml, b_err;
    logic [0:0]    b_raddr;
    logic [DW-1:0] b_rdata = '0, b_md;
    logic [15:0]   b_bc;

    dst_send_ctrl #(.DATA_W(DW), .DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .run(a_run), .s_fin_in(a_fin), .dst_ready(a_dst_ready),
        .buf_rden(a_rden), .buf_raddr(a_raddr), .buf_rdata(a_rdata), .m_valid(a_mv),
        .m_ready(a_rdy), .m_data(a_md), .m_last(a_ml), .batch_cnt(a_bc), .err_overrun(a_err)
    );

    dst_send_ctrl #(.DATA_W(DW), .DEPTH(1)) u_b (
        .clk(clk), .rst_n(rst_n), .run(b_run), .s_fin_in(b_fin), .dst_ready(b_dst_ready),
        .buf_rden(b_rden), .buf_raddr(b_raddr), .buf_rdata(b_rdata), .m_valid(b_mv),
        .m_ready(b_rdy), .m_data(b_md), .m_last(b_ml), .batch_cnt(b_bc), .err_overrun(b_err)
    );

    // Buffer model: one-cycle read latency.
    logic [DW-1:0] mem_a [4];
    logic [DW-1:0] mem_b;
    always @(posedge clk) begin
        if (a_rden) a_rdata <= mem_a[a_raddr];
        if (b_rden) b_rdata <= mem_b;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor for the DEPTH=4 instance: records accepted words, checks stall hold
    // and that no read is issued while two fetched words are still undelivered.
    logic [DW-1:0] a_q [$];
    logic          a_lq [$];
    int            a_issued = 0, a_sent = 0;
    logic          prev_stall = 1'b0, prev_l = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (rst_n && a_run) begin
            if (prev_stall) begin
                chk("hold_valid", a_mv, 1);
                chk("hold_data", a_md, prev_d);
                chk("hold_last", a_ml, prev_l);
            end
            if (a_rden) begin
                chk("rden_cap", (a_issued - a_sent) < 2, 1);
                a_issued++;
            end
            if (a_mv && a_rdy) begin
                a_q.push_back(a_md);
                a_lq.push_back(a_ml);
                a_sent++;
            end
            prev_stall = a_mv && !a_rdy;
            prev_d     = a_md;
            prev_l     = a_ml;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [DW-1:0] exp_a [4];
    int            exp_bc_a = 0;

    task automatic load_a();
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = $urandom;
            exp_a[i] = mem_a[i];
        end
        a_q.delete();
        a_lq.delete();
        a_issued = 0;
        a_sent   = 0;
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, a_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < a_q.size()) begin
                chk({tag, "_data"}, a_q[i], exp_a[i]);
                chk({tag, "_last"}, a_lq[i], (i == 3));
            end
        end
    endtask

    // mode 0: m_ready high, 1: pattern 1,0,0,1,0,1..., 2: random
    task automatic batch_a(input int mode, input string tag);
        int cyc;
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        load_a();
        chk({tag, "_idle"}, a_dst_ready, 1);
        a_rdy = 1'b0;
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        cyc = 0;
        while (a_sent < 4 && cyc < 200) begin
            case (mode)
                0:       a_rdy = 1'b1;
                1:       a_rdy = pat[cyc % 6];
                default: a_rdy = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        a_rdy = 1'b0;
        chk({tag, "_timeout"}, cyc < 200, 1);
        exp_bc_a++;
        @(negedge clk);
        chk({tag, "_done_rdy"}, a_dst_ready, 1);
        chk({tag, "_bc"}, a_bc, exp_bc_a);
        check_q(tag);
    endtask

    initial begin
        logic [DW-1:0] x0, x1;
        a_run = 1'b1;
        b_run = 1'b1;
        #3;
        chk("rst_dst_ready", a_dst_ready, 0);
        chk("rst_mv", a_mv, 0);
        chk("rst_rden", a_rden, 0);
        chk("rst_last", a_ml, 0);
        chk("rst_bc", a_bc, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_dst_ready", b_dst_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_ready", a_dst_ready, 1);

        // Directed latency with m_ready high
        tick();
        load_a();
        a_rdy = 1'b1;
        a_fin = 1'b1;
        @(negedge clk);
        chk("t1_rden_T", a_rden, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            a_fin = 1'b0;
            @(negedge clk);
            chk("t1_rden", a_rden, (k <= 4));
            if (k <= 4) chk("t1_raddr", a_raddr, k - 1);
            chk("t1_mv", a_mv, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) chk("t1_data", a_md, exp_a[k-2]);
            chk("t1_last", a_ml, (k == 5));
            chk("t1_dst_ready", a_dst_ready, (k == 6));
        end
        exp_bc_a++;
        chk("t1_bc", a_bc, exp_bc_a);
        check_q("t1");
        a_rdy = 1'b0;
        tick();

        // Backpressure
        batch_a(1, "t2_pat");
        for (int r = 0; r < 4; r++) batch_a(2, "t2_rnd");
        batch_a(0, "t2_full");

        // Overrun: second s_fin_in at T+3
        tick();
        load_a();
        a_rdy = 1'b1;
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        tick();
        chk("t3_err_pre", a_err, 0);
        tick();
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        @(negedge clk);
        chk("t3_err_set", a_err, 1);
        repeat (2) tick();
        @(negedge clk);
        chk("t3_done_rdy", a_dst_ready, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("t3_no_restart_rden", a_rden, 0);
        chk("t3_no_restart_mv", a_mv, 0);
        chk("t3_err_sticky", a_err, 1);
        exp_bc_a++;
        chk("t3_bc", a_bc, exp_bc_a);
        check_q("t3");

        // run=0 mid-batch
        tick();
        load_a();
        a_rdy = 1'b1;
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        tick();
        tick();
        a_run = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_mv", a_mv, 0);
        chk("t4_dst_ready", a_dst_ready, 0);
        chk("t4_rden", a_rden, 0);
        chk("t4_err_clr", a_err, 0);
        chk("t4_bc_held", a_bc, exp_bc_a);
        tick();
        a_run = 1'b1;
        @(negedge clk);
        chk("t4_ready_back", a_dst_ready, 1);
        chk("t4_mv_idle", a_mv, 0);
        tick();
        batch_a(2, "t4_restream");

        // Asynchronous reset mid-stream
        tick();
        load_a();
        a_rdy = 1'b1;
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        tick();
        tick();
        chk("t5_pre_mv", a_mv, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_mv", a_mv, 0);
        chk("t5_rden", a_rden, 0);
        chk("t5_bc", a_bc, 0);
        chk("t5_dst_ready", a_dst_ready, 0);
        chk("t5_last", a_ml, 0);
        exp_bc_a = 0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_ready_after", a_dst_ready, 1);
        a_rdy = 1'b0;

        // DEPTH=1 back-to-back batches
        tick();
        x0 = $urandom;
        x1 = $urandom;
        mem_b = x0;
        b_rdy = 1'b1;
        b_fin = 1'b1;
        @(negedge clk);
        chk("t6_ready_T", b_dst_ready, 1);
        tick();
        b_fin = 1'b0;
        @(negedge clk);
        chk("t6_rden1", b_rden, 1);
        chk("t6_raddr1", b_raddr, 0);
        chk("t6_mv1", b_mv, 0);
        tick();
        @(negedge clk);
        chk("t6_mv2", b_mv, 1);
        chk("t6_data2", b_md, x0);
        chk("t6_last2", b_ml, 1);
        chk("t6_rden2", b_rden, 0);
        mem_b = x1;
        tick();
        b_fin = 1'b1;
        @(negedge clk);
        chk("t6_ready3", b_dst_ready, 1);
        chk("t6_bc3", b_bc, 1);
        chk("t6_mv3", b_mv, 0);
        tick();
        b_fin = 1'b0;
        @(negedge clk);
        chk("t6_rden4", b_rden, 1);
        chk("t6_raddr4", b_raddr, 0);
        chk("t6_ready4", b_dst_ready, 0);
        tick();
        @(negedge clk);
        chk("t6_mv5", b_mv, 1);
        chk("t6_data5", b_md, x1);
        chk("t6_last5", b_ml, 1);
        tick();
        @(negedge clk);
        chk("t6_ready6", b_dst_ready, 1);
        chk("t6_bc6", b_bc, 2);
        chk("t6_err", b_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dst_send_ctrl.md
Name: dst_send_ctrl

Overview:
Transmit-side counterpart of the source/compute control. It waits for the compute side to report that a finished result batch sits in the dst buffer (s_fin_in). It then reads the batch word by word and streams it out on a valid/ready master interface. It advertises dst_ready whenever it is idle, so the compute side may complete the next batch into the buffer.

Parameters:
DATA_W, 32, width of one dst buffer word and of m_data
DEPTH, 16, words per result batch (>=1)
ADDR_W, $clog2(DEPTH) (min 1), dst buffer read address width

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
run  input  1  synchronous enable; low = synchronous clear to IDLE
s_fin_in  input  1  one-cycle pulse: full batch present in dst buffer
dst_ready  output  1  sender idle, batch may be handed over / buffer may be overwritten
buf_rden  output  1  dst buffer read enable
buf_raddr  output  ADDR_W  dst buffer read address
buf_rdata  input  DATA_W  read data, valid exactly 1 cycle after buf_rden
m_valid  output  1  stream word valid
m_ready  input  1  downstream accept
m_data  output  DATA_W  stream word
m_last  output  1  marks final word of a batch
batch_cnt  output  16  batches fully sent, wraps 0xFFFF->0
err_overrun  output  1  sticky: s_fin_in seen while busy

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rd_cnt=0, out_cnt=0, skid FIFO empty, buf_rden=0, m_valid=0, m_last=0, batch_cnt=0, err_overrun=0. dst_ready is 0 during reset and 1 once rst_n=1 and run=1.
- run=0 at a clock edge: same clear as reset, except batch_cnt is held. This covers a mid-batch clear: FIFO contents are discarded and m_valid drops the next cycle.
- dst_ready = (state==IDLE) & run, decoded from the registered state.
- States:
  - IDLE: s_fin_in=1 -> STREAM, rd_cnt=0, out_cnt=0.
  - STREAM: reads are issued and words are sent. When the word with out_cnt==DEPTH-1 transfers (m_valid & m_ready): batch_cnt++ and -> IDLE.
- s_fin_in while state!=IDLE is ignored and sets err_overrun. err_overrun is cleared only by reset or run=0.
- Read issue, STREAM only:
  - buf_rden=1 when rd_cnt<DEPTH and (FIFO occupancy + reads in flight) < 2.
  - buf_raddr=rd_cnt; rd_cnt increments per issued read.
  - Returned buf_rdata is written into a 2-entry skid FIFO the cycle after buf_rden.
- Output:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - A transfer occurs when m_valid & m_ready; it pops the head and increments out_cnt.
  - m_data and m_last are stable while m_valid & ~m_ready.
  - A simultaneous push and pop on the FIFO is allowed.
- m_last = m_valid & (out_cnt==DEPTH-1). With DEPTH=1, m_last is set on the first word.
- Latency: s_fin_in at cycle T -> buf_rden with addr 0 at T+1 -> m_valid with word 0 at T+2.
  - With m_ready held high: one word per cycle, last word at T+1+DEPTH, dst_ready=1 at T+2+DEPTH.
  - No bubble between words under continuous m_ready.
- Backpressure: with m_ready low, at most 2 words are buffered and no further reads are issued. Resume is at full rate with no lost or duplicated word.
- s_fin_in in the same cycle the IDLE transition is decoded (i.e. while dst_ready=1) is accepted. A new batch may therefore start the cycle after the previous m_last transfer.
- Address wrap: rd_cnt counts 0..DEPTH; buf_raddr uses only values 0..DEPTH-1.

Test Plan:
- DEPTH=4, buffer words A0..A3, m_ready=1, s_fin_in at T -> rden at T+1..T+4 (addr 0..3), m_data A0..A3 at T+2..T+5, m_last only at T+5, dst_ready=1 at T+6, batch_cnt=1.
- Same batch, m_ready toggling 1,0,0,1,0,1,... -> A0..A3 delivered in order with none dropped or duplicated; m_data is held during stalls; no rden issued while 2 words are buffered.
- s_fin_in pulsed again at T+3 during a batch -> err_overrun=1 and stays 1; the batch finishes normally; batch_cnt=1; no second batch starts.
- run=0 at T+3 mid-batch -> m_valid=0 and dst_ready=0 the next cycle; after run=1, dst_ready=1; a new s_fin_in restreams from addr 0.
- rst_n asserted asynchronously mid-stream (between clock edges) -> m_valid, buf_rden, and batch_cnt go to 0 immediately, without waiting for a clock edge.
- DEPTH=1, two back-to-back batches with s_fin_in asserted the cycle dst_ready rises -> each word has m_last=1; batch_cnt=2.
